// File: rtl/dpu_sequencer_pkg.sv
// Shared DPU definitions: command layout, opcodes and sequencer state encoding.
// The SRAM controller imports the same package, so both sides agree on these values.
package dpu_sequencer_pkg;

  localparam int CMD_W        = 8;
  localparam int CMD_MARK_BIT = 7;
  localparam int CMD_OP_MSB   = 6;
  localparam int CMD_OP_LSB   = 5;
  localparam int CMD_ADDR_MSB = 4;
  localparam int CMD_ADDR_LSB = 0;
  localparam int ADDR_W       = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;
  localparam int DATA_W       = 32;
  localparam int COUNT_W      = 8;

  typedef enum logic [1:0] {
    OP_INC = 2'b00,
    OP_INV = 2'b01,
    OP_REV = 2'b10,
    OP_POP = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RD_REQ = 2'b01,
    ST_CALC   = 2'b10,
    ST_WR_REQ = 2'b11
  } state_e;

  typedef struct packed {
    logic              marker;
    opcode_e           op;
    logic [ADDR_W-1:0] addr;
  } dpu_cmd_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/dpu_sequencer_if.sv
// Command and SRAM-handshake bundle between the host/controller and the DPU sequencer.
interface dpu_sequencer_if;
  import dpu_sequencer_pkg::*;

  logic                dpu_load_cmd;
  logic [CMD_W-1:0]    nxt_cmd;
  logic                requst_valid;
  logic [DATA_W-1:0]   sram_data_to_dpu;
  logic                read_requst;
  logic                send_request;
  logic [ADDR_W-1:0]   sram_addr_from_dpu;
  logic [DATA_W-1:0]   sram_data_from_dpu;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  cmd_count;

  // Host / SRAM controller side.
  modport master (
    output dpu_load_cmd, nxt_cmd, requst_valid, sram_data_to_dpu,
    input  read_requst, send_request, sram_addr_from_dpu, sram_data_from_dpu,
    input  busy, done, cmd_count
  );

  // DPU sequencer side.
  modport slave (
    input  dpu_load_cmd, nxt_cmd, requst_valid, sram_data_to_dpu,
    output read_requst, send_request, sram_addr_from_dpu, sram_data_from_dpu,
    output busy, done, cmd_count
  );
endinterface

// File: rtl/dpu_sequencer_alu.sv
// Combinational DPU datapath: one 32-bit result from opcode and operand.
module dpu_alu
  import dpu_sequencer_pkg::*;
(
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] operand_i,
  output logic [DATA_W-1:0] result_o
);

  logic [5:0] pop_cnt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pop_cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop_cnt = pop_cnt + 6'(operand_i[i]);
    end
  end

  always_comb begin
    result_o = '0;
    unique case (op_i)
      OP_INC: begin
        for (int b = 0; b < 4; b++) begin
          result_o[b*8 +: 8] = operand_i[b*8 +: 8] + 8'd1;
        end
      end
      OP_INV:  result_o = ~operand_i;
      OP_REV:  result_o = {operand_i[7:0], operand_i[15:8], operand_i[23:16], operand_i[31:24]};
      OP_POP:  result_o = {26'd0, pop_cnt};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/dpu_sequencer.sv
// DPU command sequencer: read word, transform it in one CALC cycle, write it back.
module dpu_sequencer
  import dpu_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  dpu_sequencer_if.slave   bus
);

  state_e             state_q, state_d;
  opcode_e            op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  operand_q, operand_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [DATA_W-1:0]  alu_result;
  dpu_cmd_t           cmd;

  assign cmd = dpu_cmd_t'(bus.nxt_cmd);

  dpu_alu u_alu (
    .op_i      (op_q),
    .operand_i (operand_q),
    .result_o  (alu_result)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    result_d  = result_q;
    done_d    = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      ST_IDLE: begin
        // Only idle accepts commands, so a pulse while busy never relatches.
        if (bus.dpu_load_cmd && cmd.marker) begin
          op_d    = cmd.op;
          addr_d  = cmd.addr;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (bus.requst_valid) begin
          operand_d = bus.sram_data_to_dpu;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        result_d = alu_result;
        state_d  = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (bus.requst_valid) begin
          done_d  = 1'b1;
          count_d = sat_inc(count_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every register here has a defined reset value; none is left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_INC;
      addr_q    <= '0;
      operand_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  // Requests decode from the registered state, so they are mutually exclusive and drop with reset.
  assign bus.read_requst        = (state_q == ST_RD_REQ);
  assign bus.send_request       = (state_q == ST_WR_REQ);
  assign bus.sram_addr_from_dpu = addr_q;
  assign bus.sram_data_from_dpu = result_q;
  assign bus.busy               = (state_q != ST_IDLE);
  assign bus.done               = done_q;
  assign bus.cmd_count          = count_q;

endmodule

// File: tb/tb_dpu_sequencer.sv
// Directed bench for dpu_sequencer: opcode vectors, latency, ignore rules, reset abort, saturation.
module tb_dpu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dpu_sequencer_if bus ();

  dpu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int exp_done = 0;
  logic [7:0] exp_count = 8'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) done_seen <= done_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".rd"},   32'(bus.read_requst), 32'd0);
    check({tag, ".wr"},   32'(bus.send_request), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  // One full command; waits are the idle cycles spent in RD_REQ / WR_REQ before requst_valid.
  task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] rd_data,
                         input int rd_wait, input int wr_wait,
                         input logic [31:0] exp_data, input bit inject);
    logic [4:0] exp_addr;
    int start;
    exp_addr = cmd[4:0];
    bus.dpu_load_cmd = 1'b1;
    bus.nxt_cmd      = cmd;
    @(negedge clk);
    start = cyc;
    bus.dpu_load_cmd = 1'b0;
    check("rd.req",  32'(bus.read_requst), 32'd1);
    check("rd.busy", 32'(bus.busy), 32'd1);
    check("rd.addr", 32'(bus.sram_addr_from_dpu), 32'(exp_addr));
    for (int k = 0; k < rd_wait; k++) begin
      bus.dpu_load_cmd = inject && (k == 0);
      bus.nxt_cmd      = inject ? 8'hFF : cmd;
      @(negedge clk);
      check("rd.hold", 32'(bus.read_requst), 32'd1);
      check("rd.addr_stable", 32'(bus.sram_addr_from_dpu), 32'(exp_addr));
    end
    bus.dpu_load_cmd     = 1'b0;
    bus.requst_valid     = 1'b1;
    bus.sram_data_to_dpu = rd_data;
    @(negedge clk);
    bus.requst_valid     = 1'b0;
    bus.sram_data_to_dpu = 32'hDEAD_BEEF;
    check("calc.no_req", 32'({bus.read_requst, bus.send_request}), 32'd0);
    @(negedge clk);
    check("wr.req",  32'(bus.send_request), 32'd1);
    check("wr.rd0",  32'(bus.read_requst), 32'd0);
    check("wr.data", bus.sram_data_from_dpu, exp_data);
    check("wr.addr", 32'(bus.sram_addr_from_dpu), 32'(exp_addr));
    for (int k = 0; k < wr_wait; k++) begin
      @(negedge clk);
      check("wr.hold", 32'(bus.send_request), 32'd1);
      check("wr.addr_stable", 32'(bus.sram_addr_from_dpu), 32'(exp_addr));
    end
    bus.requst_valid = 1'b1;
    @(negedge clk);
    bus.requst_valid = 1'b0;
    exp_count = (exp_count == 8'd255) ? 8'd255 : exp_count + 8'd1;
    exp_done++;
    check("done.pulse", 32'(bus.done), 32'd1);
    check("done.count", 32'(bus.cmd_count), 32'(exp_count));
    check("done.latency", 32'(cyc - start), 32'(rd_wait + wr_wait + 3));
    check_idle_outputs("done");
  endtask

  initial begin
    int snap;
    logic [31:0] d;
    bus.dpu_load_cmd     = 1'b0;
    bus.nxt_cmd          = 8'h00;
    bus.requst_valid     = 1'b0;
    bus.sram_data_to_dpu = 32'h0;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset.done",  32'(bus.done), 32'd0);
    check("reset.count", 32'(bus.cmd_count), 32'd0);
    check("reset.addr",  32'(bus.sram_addr_from_dpu), 32'd0);
    check("reset.data",  bus.sram_data_from_dpu, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-DPU command and a stray requst_valid in IDLE must not start anything.
    bus.dpu_load_cmd = 1'b1;
    bus.nxt_cmd      = 8'h03;
    @(negedge clk);
    bus.dpu_load_cmd = 1'b0;
    check_idle_outputs("nomark");
    bus.requst_valid = 1'b1;
    @(negedge clk);
    bus.requst_valid = 1'b0;
    check_idle_outputs("idle_valid");
    check("idle_valid.count", 32'(bus.cmd_count), 32'd0);
    check("idle_valid.done",  32'(bus.done), 32'd0);

    run_cmd(8'h83, 32'h12FF_00AB, 0, 0, 32'h1300_01AC, 1'b0);
    @(negedge clk);
    check("inc.done_once", 32'(bus.done), 32'd0);
    run_cmd(8'hA0, 32'h0000_FFFF, 1, 2, 32'hFFFF_0000, 1'b0);
    run_cmd(8'hDF, 32'h1122_3344, 2, 1, 32'h4433_2211, 1'b0);
    run_cmd(8'hE5, 32'hF0F0_F0F1, 0, 3, 32'h0000_0011, 1'b0);
    run_cmd(8'hC9, 32'h0000_0000, 0, 0, 32'h0000_0000, 1'b0);
    run_cmd(8'h9E, 32'hFFFF_FFFF, 10, 10, 32'h0000_0000, 1'b1);
    @(negedge clk);
    check("total_done", 32'(done_seen), 32'(exp_done));

    // Reset asserted while in WR_REQ aborts the command at once.
    bus.dpu_load_cmd = 1'b1;
    bus.nxt_cmd      = 8'h87;
    @(negedge clk);
    bus.dpu_load_cmd     = 1'b0;
    bus.requst_valid     = 1'b1;
    bus.sram_data_to_dpu = 32'h0102_0304;
    @(negedge clk);
    bus.requst_valid = 1'b0;
    @(negedge clk);
    check("abort.wr_req", 32'(bus.send_request), 32'd1);
    check("abort.wr_data", bus.sram_data_from_dpu, 32'h0203_0405);
    snap = done_seen;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    check("abort.done",  32'(bus.done), 32'd0);
    check("abort.count", 32'(bus.cmd_count), 32'd0);
    check("abort.addr",  32'(bus.sram_addr_from_dpu), 32'd0);
    check("abort.data",  bus.sram_data_from_dpu, 32'd0);
    bus.requst_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.requst_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_abort");
    check("post_abort.count", 32'(bus.cmd_count), 32'd0);
    check("post_abort.no_done", 32'(done_seen), 32'(snap));
    exp_count = 8'd0;

    // 256 back-to-back completions: counter saturates at 255, done still pulses.
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      run_cmd({3'b101, 5'(i)}, d, 0, 0, ~d, 1'b0);
    end
    check("sat.count", 32'(bus.cmd_count), 32'd255);
    @(negedge clk);
    check("sat.total_done", 32'(done_seen), 32'(exp_done));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dpu_sequencer.md
DPU_SEQUENCER -- requirements
Module: dpu_sequencer

Interface
REQ-001 SHALL have no parameters; all widths are fixed by the command and SRAM formats.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 dpu_load_cmd  input  1  one-cycle pulse; nxt_cmd valid this cycle.
REQ-005 nxt_cmd  input  8  DPU command: [7]=1 DPU marker, [6:5] opcode, [4:0] word address.
REQ-006 requst_valid  input  1  controller pulse: read data valid (1st), write complete (2nd).
REQ-007 sram_data_to_dpu  input  32  read word; valid only while requst_valid=1 in read phase.
REQ-008 read_requst  output  1  level request for SRAM read at sram_addr_from_dpu.
REQ-009 send_request  output  1  level request for SRAM write of sram_data_from_dpu.
REQ-010 sram_addr_from_dpu  output  5  target word address.
REQ-011 sram_data_from_dpu  output  32  result word to write.
REQ-012 busy  output  1  high from the cycle after command accept until return to IDLE.
REQ-013 done  output  1  one-cycle pulse on write completion.
REQ-014 cmd_count  output  8  completed-command count, saturating at 255.

Function
REQ-015 FSM states SHALL be IDLE, RD_REQ, CALC, WR_REQ; encoding registered, 2 bits.
REQ-016 IDLE: on dpu_load_cmd=1 with nxt_cmd[7]=1, latch opcode and address, go to RD_REQ; nxt_cmd[7]=0 or no pulse -> stay IDLE.
REQ-017 RD_REQ: read_requst=1 held every cycle; on requst_valid=1 capture sram_data_to_dpu into operand register, go to CALC.
REQ-018 CALC: exactly one cycle; result register = f(opcode, operand); go to WR_REQ.
REQ-019 Opcode 00: per-byte increment, each byte +1 mod 256, no carry between bytes.
REQ-020 Opcode 01: bitwise invert of all 32 bits.
REQ-021 Opcode 10: byte reverse {b0,b1,b2,b3}.
REQ-022 Opcode 11: population count of operand in bits [5:0], bits [31:6]=0.
REQ-023 WR_REQ: send_request=1 held, sram_data_from_dpu=result register, sram_addr_from_dpu=latched address; on requst_valid=1 pulse done, increment cmd_count (saturating), go to IDLE.
REQ-024 sram_addr_from_dpu SHALL be stable from RD_REQ entry through WR_REQ exit; read_requst and send_request never both high.
REQ-025 Latency: with requst_valid returned N cycles after request, done pulse occurs (N_rd + N_wr + 3) cycles after dpu_load_cmd.
REQ-026 dpu_load_cmd while busy SHALL be ignored (no relatch, no state change).
REQ-027 requst_valid in IDLE or CALC SHALL be ignored.
REQ-028 cmd_count at 255 SHALL remain 255 on further completions; done still pulses.

Reset
REQ-029 rst_n low SHALL force IDLE, read_requst=0, send_request=0, busy=0, done=0, cmd_count=0, address/operand/result registers=0, sram outputs=0.
REQ-030 Reset asserted mid-command SHALL abort immediately; no done pulse and no count increment after release.

Structure
REQ-031 Opcode constants (OP_INC, OP_INV, OP_REV, OP_POP), command field positions and state encodings SHALL live in a shared package used also by the SRAM controller.
REQ-032 Result computation SHALL be one combinational sub-module dpu_alu (opcode, 32-bit operand -> 32-bit result).

Verification
REQ-033 Cmd 0x83, read returns 0x12FF00AB -> write 0x1300_01AC to addr 3, done once, cmd_count=1.
REQ-034 Cmd 0xA0, read 0x0000FFFF -> write 0xFFFF0000 to addr 0; cmd 0xDF, read 0x11223344 -> write 0x44332211 to addr 31.
REQ-035 Cmd 0xE5, read 0xF0F0F0F1 -> write 0x00000011 to addr 5.
REQ-036 requst_valid delayed 10 cycles in RD_REQ and WR_REQ -> requests held, address stable, done at cycle 23; extra dpu_load_cmd mid-command ignored.
REQ-037 rst_n low during WR_REQ -> outputs zero asynchronously, no done; then 256 back-to-back commands -> cmd_count=255.
